// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction geometry, fetch FSM states
// and opcode field layout used by fetch and decode.
package cpu_pkg;

    localparam int CPU_AW = 11;
    localparam int CPU_IW = 9;
    localparam logic [CPU_IW-1:0] CPU_HALT_OP = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT_WAIT,
        HALTED
    } fetch_state_t;

    // Top three bits select the instruction class; the rest is operand.
    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OPC_ALU    = 3'b000;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 3'b001;
    localparam logic [OPC_W-1:0] OPC_STORE  = 3'b010;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 3'b011;
    localparam logic [OPC_W-1:0] OPC_IMM    = 3'b100;
    localparam logic [OPC_W-1:0] OPC_SYS    = 3'b111;

    function automatic logic [OPC_W-1:0] opcode_of(
        input logic [CPU_IW-1:0] inst
    );
        return inst[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/inst_fetch_prog_counter.sv
// Program counter register: load has priority over increment,
// increment wraps modulo 2**AW, otherwise the value holds.
module prog_counter #(
    parameter int AW = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          inc_i,
    output logic [AW-1:0] pc_o
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, registers the ROM word into a
// valid/ready fetch stage, handles redirects and halt retirement.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int            AW      = CPU_AW,
    parameter int            IW      = CPU_IW,
    parameter logic [IW-1:0] HALT_OP = CPU_HALT_OP
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [AW-1:0] StartAddr,
    output logic [AW-1:0] InstAddress,
    input  logic [IW-1:0] InstIn,
    output logic [IW-1:0] Inst,
    output logic [AW-1:0] InstPC,
    output logic          InstValid,
    input  logic          DecReady,
    input  logic          BranchEn,
    input  logic [AW-1:0] BranchTarget,
    output logic          Done
);

    fetch_state_t  state_q, state_d;
    logic [IW-1:0] inst_q, inst_d;
    logic [AW-1:0] inst_pc_q, inst_pc_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;

    logic [AW-1:0] pc;
    logic          pc_load;
    logic [AW-1:0] pc_load_val;
    logic          pc_inc;
    logic          slot_free;
    logic          in_halt;

    assign slot_free = !valid_q || DecReady;
    assign in_halt   = (InstIn == HALT_OP);

    prog_counter #(
        .AW(AW)
    ) u_pc (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        valid_d     = valid_q;
        done_d      = done_q;
        pc_load     = 1'b0;
        pc_load_val = '0;
        pc_inc      = 1'b0;
        unique case (state_q)
            IDLE, HALTED: begin
                if (Start) begin
                    pc_load     = 1'b1;
                    pc_load_val = StartAddr;
                    done_d      = 1'b0;
                    valid_d     = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (BranchEn) begin
                    pc_load     = 1'b1;
                    pc_load_val = BranchTarget;
                    valid_d     = 1'b0;
                end else if (slot_free) begin
                    inst_d    = InstIn;
                    inst_pc_d = pc;
                    valid_d   = 1'b1;
                    // A halt word parks the PC on itself.
                    if (in_halt) begin
                        state_d = HALT_WAIT;
                    end else begin
                        pc_inc = 1'b1;
                    end
                end
            end
            HALT_WAIT: begin
                if (BranchEn) begin
                    pc_load     = 1'b1;
                    pc_load_val = BranchTarget;
                    valid_d     = 1'b0;
                    state_d     = RUN;
                end else if (valid_q && DecReady) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = HALTED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign InstAddress = pc;
    assign Inst        = inst_q;
    assign InstPC      = inst_pc_q;
    assign InstValid   = valid_q;
    assign Done        = done_q;

endmodule
